alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command front-end for the 8-bit combinational `alu`: accepts ALU commands over a valid/ready handshake, buffers them in a small FIFO, and drives `A`, `B` and `ALU_Sel` from registers. It captures `ALU_Out`/`CarryOut` into a result register with flags, keeps an 8-bit accumulator for chained operations, and presents each result downstream over a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; power of 2, minimum 2.
- `ACC_INIT`, default 8'h00: accumulator reset value.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: equals `!fifo_full`.
- `cmd_op` in 4: ALU opcode, using the `ALU_Sel` encoding.
- `cmd_src` in 1: operand routing.
  - 0: `A` = acc, `B` = `cmd_data`.
  - 1: `A` = `cmd_data`, `B` = acc.
- `cmd_data` in 8: immediate operand.
- `cmd_wb` in 1: write the result back to acc.
- `A` out 8: to the ALU.
- `B` out 8: to the ALU.
- `ALU_Sel` out 4: to the ALU.
- `ALU_Out` in 8: from the ALU.
- `CarryOut` in 1: from the ALU.
- `res_valid` out 1: result present.
- `res_ready` in 1: downstream accepts the result.
- `res_data` out 8: result value.
- `res_carry` out 1: carry flag.
- `res_zero` out 1: zero flag.
- `acc` out 8: accumulator value.
- `err_div0` out 1: sticky divide-by-zero error.

## Operation
- **Command accept:** a command is pushed on `cmd_valid && cmd_ready`. There is no bypass; every command passes through the FIFO.
- **Reset values:**
  - `A`, `B`, `ALU_Sel`, `res_data`, `res_carry`, `res_zero`, `res_valid`, `err_div0`: 0.
  - `acc`: `ACC_INIT`.
  - FIFO: empty, so `cmd_ready` is 1.
  - FSM: IDLE.
- **IDLE:**
  - If the FIFO is non-empty: pop the head.
  - Register `A`/`B` per `cmd_src`, using the current `acc`.
  - Register `ALU_Sel` from `cmd_op`; register `cmd_wb`.
  - Go to ISSUE.
- **ISSUE (one cycle):** the ALU settles. At the closing edge:
  - `res_data` ← `ALU_Out`.
  - `res_carry` ← `CarryOut` if `ALU_Sel` is 4'b0000, else 0.
  - `res_zero` ← (`ALU_Out` == 0).
  - `res_valid` ← 1.
  - `acc` ← `ALU_Out` if wb is set.
  - Go to HOLD.
- **HOLD:**
  - `res_*` outputs are stable while `res_valid && !res_ready`.
  - On handshake with the FIFO non-empty: pop and go directly to ISSUE. `res_valid` drops for that cycle.
  - On handshake with the FIFO empty: go to IDLE, `res_valid` ← 0.
- **Idle outputs:** `A`, `B` and `ALU_Sel` hold their last values whenever the FSM is not in ISSUE.
- **Accumulator hazard:** none. `acc` is written at the ISSUE edge, and the next pop samples it at a later edge.
- **FIFO boundaries:**
  - Full: `cmd_ready` is 0 and the push is ignored, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: both occur and the count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset mid-operation:** asynchronous clear of all state. In-flight and buffered commands are discarded.

## Timing
- **Accept to result:** command accepted at edge k (FIFO empty, FSM IDLE).
  - Edge k+1: pop; `A`/`B`/`ALU_Sel` valid.
  - Edge k+2: `res_valid` = 1 and `acc` updated.
- **Throughput:** with `res_ready` held at 1, one result every 2 cycles.
- **Capacity:** at most `FIFO_DEPTH` + 1 commands outstanding, i.e. `FIFO_DEPTH` in the FIFO plus 1 in ISSUE/HOLD.
- **Combinational paths:** `cmd_ready` depends only on registered state. No combinational path from `res_ready` to `cmd_ready`.

## Configuration
- **`ALU_SEQ_DIV0_TRAP_EN` defined:** when an ISSUE has `ALU_Sel` = 4'b0011 and `B` = 0:
  - `res_data` = 8'hFF, `res_carry` = 0, `res_zero` = 0.
  - `acc` is not written, regardless of wb.
  - `err_div0` is set; it is sticky until reset.
- **`ALU_SEQ_DIV0_TRAP_EN` undefined:**
  - `ALU_Out` is captured unmodified for every op.
  - `err_div0` is tied to 0.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-HOLD with 3 commands queued → all outputs at reset values immediately, `cmd_ready` = 1, `acc` = `ACC_INIT`. After release, no `res_valid` without new commands.
- **Add with carry chain:**
  - Step 1: op 1001, src 0, data 8'hF0, wb 1 → `res_data` 8'hF0, `acc` 8'hF0.
  - Step 2: op 0000, data 8'h20, wb 1 → `res_data` 8'h10, `res_carry` 1, `res_zero` 0, `acc` 8'h10, `res_valid` exactly 2 cycles after accept.
- **Source swap subtract:** with `acc` = 8'h05, op 0001, src 1, data 8'h03 → `A` 8'h03, `B` 8'h05, `res_data` 8'hFE, `res_carry` 0.
- **Backpressure:** `res_ready` = 0 while pushing continuously → exactly `FIFO_DEPTH` + 1 (5) commands accepted, then `cmd_ready` = 0. `res_data` holds stable. Raising `res_ready` then drains the remaining 4 results in order at 1 per 2 cycles.
- **Flags:**
  - op 1010 with `acc` == data = 8'h5A → `res_data` 8'h00, `res_zero` 1.
  - op 1111 with the same operands → `res_data` 8'h01, `res_zero` 0.
- **Divide-by-zero (macro defined):** op 0011, src 0, data 8'h00, wb 1, `acc` 8'h40 → `res_data` 8'hFF, `err_div0` 1 and sticky, `acc` stays 8'h40. With the macro undefined, `err_div0` stays 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command front-end for an external 8-bit combinational ALU. Commands arrive
// over a valid/ready handshake and are buffered in a small FIFO. Each command
// is popped into registered A/B/ALU_Sel outputs, given one cycle for the ALU
// to settle, and its result is captured into a flagged result register. That
// register is offered downstream over a valid/ready handshake. An 8-bit
// accumulator supplies one operand and can optionally take the result.
//
// Build option:
//   ALU_SEQ_DIV0_TRAP_EN - when defined, a divide (ALU_Sel 4'b0011) with B == 0
//                          yields res_data 8'hFF, suppresses the accumulator
//                          write and sets the sticky err_div0 flag. When
//                          undefined, ALU_Out is captured unchanged and
//                          err_div0 is tied low.
//
// Parameters:
//   FIFO_DEPTH - command FIFO entries (power of 2, >= 2)
//   ACC_INIT   - accumulator reset value
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_src,         opcode (ALU_Sel encoding), operand routing,
//   cmd_data, cmd_wb         immediate operand, accumulator write-back
//   A, B, ALU_Sel            registered operands/opcode to the ALU
//   ALU_Out, CarryOut        ALU result inputs
//   res_valid / res_ready    result handshake
//   res_data, res_carry,     captured result, carry flag (add only),
//   res_zero                 zero flag
//   acc                      accumulator value
//   err_div0                 sticky divide-by-zero error
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] ACC_INIT   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic       cmd_src,
    input  logic [7:0] cmd_data,
    input  logic       cmd_wb,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [3:0] ALU_Sel,
    input  logic [7:0] ALU_Out,
    input  logic       CarryOut,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_zero,
    output logic [7:0] acc,
    output logic       err_div0
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic       src;
        logic [7:0] data;
        logic       wb;
    } cmd_t;

    localparam cmd_t CMD_ZERO = '{op: 4'h0, src: 1'b0, data: 8'h00, wb: 1'b0};

    state_t           state_r;
    state_t           next_state_s;
    cmd_t             fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             capture_s;
    logic             release_s;
    cmd_t             cmd_in_s;
    cmd_t             head_s;

    logic [7:0]       a_r;
    logic [7:0]       b_r;
    logic [3:0]       alu_sel_r;
    logic             wb_r;
    logic [7:0]       acc_r;
    logic [7:0]       res_data_r;
    logic             res_carry_r;
    logic             res_zero_r;
    logic             res_valid_r;

    logic [7:0]       cap_data_s;
    logic             cap_carry_s;
    logic             cap_zero_s;
    logic             acc_we_s;

    // Full/empty come straight from the registered count, so cmd_ready has
    // no combinational dependence on res_ready.
    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign cmd_ready = !full_s;
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push_s    = cmd_valid && !full_s;
    assign cmd_in_s  = '{op: cmd_op, src: cmd_src, data: cmd_data, wb: cmd_wb};
    assign head_s    = fifo_mem_r[rd_ptr_r];

    assign A         = a_r;
    assign B         = b_r;
    assign ALU_Sel   = alu_sel_r;
    assign acc       = acc_r;
    assign res_data  = res_data_r;
    assign res_carry = res_carry_r;
    assign res_zero  = res_zero_r;
    assign res_valid = res_valid_r;

    // Command FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= CMD_ZERO;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= cmd_in_s;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and control strobes. HOLD chains straight into ISSUE
    // when another command is waiting, giving one result per two cycles.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                capture_s    = 1'b1;
                next_state_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    release_s = 1'b1;
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        next_state_s = ST_ISSUE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand/opcode registers: loaded only on a pop, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            alu_sel_r <= 4'h0;
            wb_r      <= 1'b0;
        end else if (pop_s) begin
            a_r       <= head_s.src ? head_s.data : acc_r;
            b_r       <= head_s.src ? acc_r : head_s.data;
            alu_sel_r <= head_s.op;
            wb_r      <= head_s.wb;
        end
    end

`ifdef ALU_SEQ_DIV0_TRAP_EN
    logic div0_hit_s;
    logic err_div0_r;

    // Capture values with the divide-by-zero trap overriding the ALU result.
    always_comb begin
        cap_data_s  = ALU_Out;
        cap_carry_s = (alu_sel_r == 4'b0000) ? CarryOut : 1'b0;
        cap_zero_s  = (ALU_Out == 8'h00);
        acc_we_s    = wb_r;
        div0_hit_s  = 1'b0;
        if ((alu_sel_r == 4'b0011) && (b_r == 8'h00)) begin
            div0_hit_s  = 1'b1;
            cap_data_s  = 8'hFF;
            cap_carry_s = 1'b0;
            cap_zero_s  = 1'b0;
            acc_we_s    = 1'b0;
        end else begin
            div0_hit_s  = 1'b0;
        end
    end

    // Sticky divide-by-zero flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_div0_r <= 1'b0;
        end else if (capture_s && div0_hit_s) begin
            err_div0_r <= 1'b1;
        end
    end

    assign err_div0 = err_div0_r;
`else
    // Capture values taken directly from the ALU.
    always_comb begin
        cap_data_s  = ALU_Out;
        cap_carry_s = (alu_sel_r == 4'b0000) ? CarryOut : 1'b0;
        cap_zero_s  = (ALU_Out == 8'h00);
        acc_we_s    = wb_r;
    end

    assign err_div0 = 1'b0;
`endif

    // Result register, flags and handshake valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_r  <= 8'h00;
            res_carry_r <= 1'b0;
            res_zero_r  <= 1'b0;
            res_valid_r <= 1'b0;
        end else if (capture_s) begin
            res_data_r  <= cap_data_s;
            res_carry_r <= cap_carry_s;
            res_zero_r  <= cap_zero_s;
            res_valid_r <= 1'b1;
        end else if (release_s) begin
            res_valid_r <= 1'b0;
        end
    end

    // Accumulator: written at the ISSUE edge, so the next pop sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= ACC_INIT;
        end else if (capture_s && acc_we_s) begin
            acc_r <= cap_data_s;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed bench for alu_cmd_sequencer. A behavioural 8-bit ALU drives
// ALU_Out/CarryOut from A/B/ALU_Sel; divide by zero returns 8'hFF.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic       cmd_src;
    logic [7:0] cmd_data;
    logic       cmd_wb;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       CarryOut;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic [7:0] acc;
    logic       err_div0;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_SEQ_DIV0_TRAP_EN
    localparam logic [7:0] DIV_ACC = 8'h40;
    localparam logic       DIV_ERR = 1'b1;
`else
    localparam logic [7:0] DIV_ACC = 8'hFF;
    localparam logic       DIV_ERR = 1'b0;
`endif

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ACC_INIT(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_data  (cmd_data),
        .cmd_wb    (cmd_wb),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .ALU_Out   (ALU_Out),
        .CarryOut  (CarryOut),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .acc       (acc),
        .err_div0  (err_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU.
    logic [8:0]  sum9;
    logic [15:0] prod16;
    always_comb begin
        sum9     = {1'b0, A} + {1'b0, B};
        prod16   = {8'h00, A} * {8'h00, B};
        CarryOut = sum9[8];
        case (ALU_Sel)
            4'h0:    ALU_Out = sum9[7:0];
            4'h1:    ALU_Out = A - B;
            4'h2:    ALU_Out = prod16[7:0];
            4'h3:    ALU_Out = (B == 8'h00) ? 8'hFF : (A / B);
            4'h4:    ALU_Out = A << 1;
            4'h5:    ALU_Out = A >> 1;
            4'h6:    ALU_Out = {A[6:0], A[7]};
            4'h7:    ALU_Out = {A[0], A[7:1]};
            4'h8:    ALU_Out = A & B;
            4'h9:    ALU_Out = A | B;
            4'hA:    ALU_Out = A ^ B;
            4'hB:    ALU_Out = ~(A | B);
            4'hC:    ALU_Out = ~(A & B);
            4'hD:    ALU_Out = ~(A ^ B);
            4'hE:    ALU_Out = (A > B) ? 8'h01 : 8'h00;
            default: ALU_Out = (A == B) ? 8'h01 : 8'h00;
        endcase
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one command into an idle, empty sequencer with res_ready low and
    // follow it to HOLD, checking operand and result-valid timing.
    task automatic issue_cmd(input string tag, input logic [3:0] op, input logic src,
                             input logic [7:0] data, input logic wb,
                             input logic [7:0] exp_a, input logic [7:0] exp_b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = src;
        cmd_data  = data;
        cmd_wb    = wb;
        step();
        cmd_valid = 1'b0;
        chk1({tag, "_rv_k0"}, res_valid, 1'b0);
        step();
        chk8({tag, "_A"}, A, exp_a);
        chk8({tag, "_B"}, B, exp_b);
        chk8({tag, "_sel"}, {4'h0, ALU_Sel}, {4'h0, op});
        chk1({tag, "_rv_k1"}, res_valid, 1'b0);
        step();
        chk1({tag, "_rv_k2"}, res_valid, 1'b1);
    endtask

    // Accept the held result; with nothing queued the sequencer goes idle.
    task automatic take_result(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk1({tag, "_rv_drop"}, res_valid, 1'b0);
    endtask

    task automatic chk_res(input string tag, input logic [7:0] d, input logic c,
                           input logic z, input logic [7:0] a);
        chk8({tag, "_data"}, res_data, d);
        chk1({tag, "_carry"}, res_carry, c);
        chk1({tag, "_zero"}, res_zero, z);
        chk8({tag, "_acc"}, acc, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_data [6];
        logic [7:0] held;
        int         accepted;

        bp_data[0] = 8'h11; bp_data[1] = 8'h22; bp_data[2] = 8'h33;
        bp_data[3] = 8'h44; bp_data[4] = 8'h55; bp_data[5] = 8'h66;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_src   = 1'b0;
        cmd_data  = 8'h00;
        cmd_wb    = 1'b0;
        res_ready = 1'b0;

        // Reset state
        step();
        step();
        chk8("rst_A", A, 8'h00);
        chk8("rst_B", B, 8'h00);
        chk8("rst_sel", {4'h0, ALU_Sel}, 8'h00);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk_res("rst", 8'h00, 1'b0, 1'b0, 8'h00);
        chk1("rst_err", err_div0, 1'b0);
        rst_n = 1'b1;
        step();

        // Add with carry chain
        issue_cmd("or_f0", 4'b1001, 1'b0, 8'hF0, 1'b1, 8'h00, 8'hF0);
        chk_res("or_f0", 8'hF0, 1'b0, 1'b0, 8'hF0);
        take_result("or_f0");
        issue_cmd("add20", 4'b0000, 1'b0, 8'h20, 1'b1, 8'hF0, 8'h20);
        chk_res("add20", 8'h10, 1'b1, 1'b0, 8'h10);
        take_result("add20");

        // Build acc = 05, then source-swapped subtract
        issue_cmd("and00", 4'b1000, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00);
        chk_res("and00", 8'h00, 1'b0, 1'b1, 8'h00);
        take_result("and00");
        issue_cmd("or05", 4'b1001, 1'b0, 8'h05, 1'b1, 8'h00, 8'h05);
        chk_res("or05", 8'h05, 1'b0, 1'b0, 8'h05);
        take_result("or05");
        issue_cmd("sub_swap", 4'b0001, 1'b1, 8'h03, 1'b0, 8'h03, 8'h05);
        chk_res("sub_swap", 8'hFE, 1'b0, 1'b0, 8'h05);
        take_result("sub_swap");

        // Flags with acc = 5A
        issue_cmd("xor5f", 4'b1010, 1'b0, 8'h5F, 1'b1, 8'h05, 8'h5F);
        chk_res("xor5f", 8'h5A, 1'b0, 1'b0, 8'h5A);
        take_result("xor5f");
        issue_cmd("xor_zero", 4'b1010, 1'b0, 8'h5A, 1'b0, 8'h5A, 8'h5A);
        chk_res("xor_zero", 8'h00, 1'b0, 1'b1, 8'h5A);
        take_result("xor_zero");
        issue_cmd("eq", 4'b1111, 1'b0, 8'h5A, 1'b0, 8'h5A, 8'h5A);
        chk_res("eq", 8'h01, 1'b0, 1'b0, 8'h5A);
        take_result("eq");
        // 5A+F0 overflows, but carry is reported only for add
        issue_cmd("and_nocarry", 4'b1000, 1'b0, 8'hF0, 1'b0, 8'h5A, 8'hF0);
        chk_res("and_nocarry", 8'h50, 1'b0, 1'b0, 8'h5A);
        take_result("and_nocarry");

        // Divide by zero with acc = 40
        issue_cmd("clr", 4'b1000, 1'b0, 8'h00, 1'b1, 8'h5A, 8'h00);
        take_result("clr");
        issue_cmd("or40", 4'b1001, 1'b0, 8'h40, 1'b1, 8'h00, 8'h40);
        take_result("or40");
        issue_cmd("div0", 4'b0011, 1'b0, 8'h00, 1'b1, 8'h40, 8'h00);
        chk_res("div0", 8'hFF, 1'b0, 1'b0, DIV_ACC);
        chk1("div0_err", err_div0, DIV_ERR);
        take_result("div0");
        issue_cmd("post_div", 4'b1000, 1'b0, 8'h00, 1'b1, DIV_ACC, 8'h00);
        chk_res("post_div", 8'h00, 1'b0, 1'b1, 8'h00);
        chk1("div0_err_sticky", err_div0, DIV_ERR);
        take_result("post_div");

        // Backpressure: push continuously with res_ready low
        accepted  = 0;
        cmd_valid = 1'b1;
        cmd_op    = 4'b1001;
        cmd_src   = 1'b0;
        cmd_wb    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cmd_data = bp_data[(accepted < 5) ? accepted : 5];
            if (cmd_ready) begin
                accepted++;
            end
            step();
        end
        cmd_valid = 1'b0;
        chk8("bp_accepted", 8'(accepted), 8'd5);
        chk1("bp_cmd_ready", cmd_ready, 1'b0);
        chk1("bp_res_valid", res_valid, 1'b1);
        chk8("bp_hold0", res_data, 8'h11);
        held = res_data;
        step();
        step();
        chk8("bp_hold_stable", res_data, held);
        res_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            chk1($sformatf("drain%0d_gap", i), res_valid, 1'b0);
            if (i == 1) begin
                chk1("drain_cmd_ready", cmd_ready, 1'b1);
            end
            step();
            chk1($sformatf("drain%0d_valid", i), res_valid, 1'b1);
            chk8($sformatf("drain%0d_data", i), res_data, bp_data[i]);
        end
        step();
        chk1("drain_done", res_valid, 1'b0);
        res_ready = 1'b0;

        // Reset mid-HOLD with 3 commands queued
        cmd_valid = 1'b1;
        cmd_op    = 4'b1001;
        cmd_src   = 1'b0;
        cmd_wb    = 1'b1;
        cmd_data  = 8'h77;
        step();
        cmd_data  = 8'h01;
        step();
        step();
        step();
        cmd_valid = 1'b0;
        chk1("pre_rst_valid", res_valid, 1'b1);
        chk8("pre_rst_acc", acc, 8'h77);
        #3;
        rst_n = 1'b0;
        #1;
        chk8("mid_rst_A", A, 8'h00);
        chk8("mid_rst_B", B, 8'h00);
        chk8("mid_rst_sel", {4'h0, ALU_Sel}, 8'h00);
        chk1("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk1("mid_rst_valid", res_valid, 1'b0);
        chk_res("mid_rst", 8'h00, 1'b0, 1'b0, 8'h00);
        chk1("mid_rst_err", err_div0, 1'b0);
        step();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk1($sformatf("post_rst_idle%0d", i), res_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
